fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction prefetch buffer between the instruction memory and the IF/ID pipeline register. It owns the fetch PC and issues one sequential word read per cycle to a synchronous instruction memory. Returned words are queued with their PC in a small FIFO. It presents {pc, pc+4, instr} to decode with a valid/ready handshake and discards all queued and in-flight fetches on a branch/jump redirect from execute.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- redirect_i  in  1  execute-stage PCSrc; flush and restart fetch
- redirect_pc_i  in  32  redirect target (E_pcTarget)
- imem_req_o  out  1  read request this cycle
- imem_addr_o  out  32  word address for request, bits [1:0] always 0
- imem_rdata_i  in  32  read data, valid exactly one cycle after an accepted request
- d_ready_i  in  1  decode accepts (inverse of decode stall)
- d_valid_o  out  1  head entry valid
- d_pc_o  out  32  PC of head entry
- d_pc_plus_4_o  out  32  d_pc_o + 4, modulo 2^32
- d_instr_o  out  32  instruction of head entry

## Operation
- State: fetch_pc, FIFO storage (DEPTH × {pc, instr}), wr_ptr, rd_ptr, count (0..DEPTH), inflight flag + inflight_pc.
- Credit: imem_req_o = !redirect_i && (count + inflight − pop < DEPTH), where pop = d_valid_o && d_ready_i. Invariant count + inflight ≤ DEPTH at every edge; the FIFO never overflows.
- Request: imem_addr_o = fetch_pc. On a request edge, inflight ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (wraps 32'hFFFF_FFFC → 0). Without a request, inflight ← 0.
- Response: if inflight at an edge, push {inflight_pc, imem_rdata_i} at wr_ptr.
- Pop: on pop at an edge, rd_ptr advances. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Outputs: d_valid_o = (count ≠ 0). When count = 0, d_pc_o, d_pc_plus_4_o and d_instr_o are driven 0. No combinational path from imem_rdata_i to the d_* outputs. An empty queue never bypasses.
- Redirect has priority over everything at that edge:
  - count ← 0, rd_ptr ← wr_ptr ← 0, inflight ← 0 (the in-flight word is dropped).
  - fetch_pc ← {redirect_pc_i[31:2], 2'b00}.
  - Any pop that cycle is ignored; decode is flushed by the hazard logic.
- Stall (d_ready_i = 0): the head holds stable and fetch continues until credit runs out, then imem_req_o = 0.

## Timing
- Reset (rst_n low, asynchronous): count 0, inflight 0, fetch_pc = RESET_PC, d_valid_o 0, d_pc_o/d_pc_plus_4_o/d_instr_o 0, imem_addr_o = RESET_PC, imem_req_o 0 while rst_n is low.
- Cycle 1 after release: request RESET_PC. Cycle 2: data returns and is pushed at the edge. Cycle 3: d_valid_o = 1, d_pc_o = RESET_PC.
- Redirect asserted in cycle n: no request in n. Request to target in n+1. Target visible on d_* in n+3 (3-cycle redirect penalty).
- Steady state with d_ready_i held 1: one instruction per cycle, and count settles at 1.
- Reset asserted mid-operation clears everything immediately, including an in-flight word. The first data cycle after release is ignored.

## Structure
- Shared package rv_pkg: XLEN = 32, ILEN = 32, RESET_PC_DEFAULT, NOP_INSTR = 32'h0000_0013 (used by decode on flush, not by this block).
- One natural sub-module: fetch_fifo (parameterised width/depth sync FIFO with push, pop, clear, count, async active-low reset). The fetch_buffer top holds the PC, credit and redirect logic.

## Test plan
- Reset release, d_ready_i = 1, imem returns addr-as-data: d_valid_o rises on cycle 3 with pc 0x0. Then pc 0x4, 0x8, … one per cycle, with d_pc_plus_4_o = pc + 4.
- Hold d_ready_i = 0 from cycle 3 (DEPTH = 4): exactly 4 entries fill, imem_req_o drops and stays 0, head stays pc 0x0. Release: pcs 0x0..0xC drain in order, then fetch resumes at 0x10.
- Redirect to 0x100 while 3 entries are queued and 1 is in flight: the next cycle has d_valid_o = 0 and imem_addr_o = 0x100. Cycle n+3 shows d_pc_o = 0x100. None of the old PCs ever appear.
- Redirect to 0x103 (misaligned): imem_addr_o = 0x100 and d_pc_o = 0x100.
- Redirect with d_ready_i = 1 while full: the pop is ignored, count becomes 0, and no overflow or underflow is flagged by the count-range assertion (0 ≤ count ≤ DEPTH).
- Set fetch_pc near the top via redirect to 0xFFFF_FFF8: sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, with d_pc_plus_4_o = 0 for the 0xFFFF_FFFC entry. Assert rst_n mid-stream: d_valid_o falls within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: word widths, reset vector and the
// {pc, instr} record carried between fetch and decode.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered head and a synchronous clear.
// When clear and push/pop arrive together, clear wins.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    do_push  = push_i && !clear_i;
    do_pop   = pop_i && !clear_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone defines which
  // entries are meaningful, so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Overflow or out-of-range occupancy means the upstream credit logic is broken.
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push_i && !clear_i && !pop_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: owns the fetch PC, issues credit-limited reads
// to a 1-cycle synchronous imem and queues {pc, instr} for decode.
module fetch_buffer import rv_pkg::*; #(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [ILEN-1:0] imem_rdata_i,
  input  logic            d_ready_i,
  output logic            d_valid_o,
  output logic [XLEN-1:0] d_pc_o,
  output logic [XLEN-1:0] d_pc_plus_4_o,
  output logic [ILEN-1:0] d_instr_o
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CRW = CW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            handshake, pop, push, req;
  logic [CW-1:0]   count;
  logic [CRW-1:0]  credit_used;
  fetch_entry_t    push_entry, head_entry;

  assign d_valid_o  = (count != '0);
  assign handshake  = d_valid_o && d_ready_i;
  assign pop        = handshake && !redirect_i;
  assign push       = inflight_q && !redirect_i;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata_i};

  // A request is only issued if its word is guaranteed a slot when it returns.
  always_comb begin
    credit_used = CRW'(count) + CRW'(inflight_q) - CRW'(handshake);
    req         = rst_n && !redirect_i && (credit_used < CRW'(DEPTH));
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = req;
    if (redirect_i) begin
      fetch_pc_d = align_word(redirect_pc_i);
      inflight_d = 1'b0;
    end else if (req) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= align_word(RESET_PC);
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (redirect_i),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .count_o (count)
  );

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;

  // Decode sees zeros rather than stale storage while the queue is empty.
  assign d_pc_o        = d_valid_o ? head_entry.pc            : '0;
  assign d_pc_plus_4_o = d_valid_o ? head_entry.pc + XLEN'(4) : '0;
  assign d_instr_o     = d_valid_o ? head_entry.instr         : '0;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a behavioural imem plus a PC scoreboard
// checked on every decode handshake.
module tb_fetch_buffer;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk           = 1'b0;
  logic        rst_n         = 1'b0;
  logic        redirect_i    = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] imem_rdata_i  = 32'h0;
  logic        d_ready_i     = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        d_valid_o;
  logic [31:0] d_pc_o;
  logic [31:0] d_pc_plus_4_o;
  logic [31:0] d_instr_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .d_ready_i     (d_ready_i),
    .d_valid_o     (d_valid_o),
    .d_pc_o        (d_pc_o),
    .d_pc_plus_4_o (d_pc_plus_4_o),
    .d_instr_o     (d_instr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // Synchronous imem: data for an accepted request appears one cycle later.
  always @(posedge clk) imem_rdata_i <= imem_req_o ? instr_of(imem_addr_o) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push_seq(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Retire the current cycle: score any handshake, then move past the edge.
  task automatic advance();
    logic [31:0] e;
    if (d_valid_o && d_ready_i && !redirect_i) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected observed_pc=%h expected=none", d_pc_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_pc", d_pc_o, e);
        check("sb_pc_plus_4", d_pc_plus_4_o, e + 32'd4);
        check("sb_instr", d_instr_o, instr_of(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; d_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    settle();
    check("rst_valid", d_valid_o, 32'h0);
    check("rst_pc", d_pc_o, 32'h0);
    check("rst_pc_plus_4", d_pc_plus_4_o, 32'h0);
    check("rst_instr", d_instr_o, 32'h0);
    check("rst_req", imem_req_o, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming with decode always ready.
    sb_push_seq(32'h0, 8);
    settle();
    check("c1_req", imem_req_o, 32'h1);
    check("c1_addr", imem_addr_o, 32'h0);
    check("c1_valid", d_valid_o, 32'h0);
    advance();
    settle();
    check("c2_valid", d_valid_o, 32'h0);
    check("c2_addr", imem_addr_o, 32'h4);
    advance();
    settle();
    check("c3_valid", d_valid_o, 32'h1);
    check("c3_pc", d_pc_o, 32'h0);
    advance();
    step(7);

    // Async reset mid-stream drops d_valid_o without a clock edge.
    d_ready_i = 1'b0;
    settle();
    check("a_head", d_pc_o, 32'h20);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", d_valid_o, 32'h0);
    check("async_req", imem_req_o, 32'h0);
    check("async_pc", d_pc_o, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stall from cycle 3: four entries fill, then requests stop.
    sb_push_seq(32'h0, 6);
    step(2);
    settle();
    check("st_c3_valid", d_valid_o, 32'h1);
    check("st_c3_pc", d_pc_o, 32'h0);
    advance();
    settle();
    check("st_c4_req", imem_req_o, 32'h1);
    check("st_c4_addr", imem_addr_o, 32'hC);
    advance();
    settle();
    check("st_c5_req", imem_req_o, 32'h0);
    check("st_c5_addr", imem_addr_o, 32'h10);
    advance();
    for (int i = 0; i < 2; i++) begin
      settle();
      check("st_hold_req", imem_req_o, 32'h0);
      check("st_hold_pc", d_pc_o, 32'h0);
      advance();
    end
    d_ready_i = 1'b1;
    settle();
    check("st_resume_req", imem_req_o, 32'h1);
    check("st_resume_addr", imem_addr_o, 32'h10);
    advance();
    step(5);

    // Redirect with three queued and one in flight; the pop is ignored.
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    exp_q.delete();
    sb_push_seq(32'h100, 3);
    settle();
    check("rd_req", imem_req_o, 32'h0);
    check("rd_old_head", d_pc_o, 32'h18);
    advance();
    redirect_i = 1'b0;
    settle();
    check("rd_n1_valid", d_valid_o, 32'h0);
    check("rd_n1_req", imem_req_o, 32'h1);
    check("rd_n1_addr", imem_addr_o, 32'h100);
    advance();
    settle();
    check("rd_n2_valid", d_valid_o, 32'h0);
    advance();
    settle();
    check("rd_n3_valid", d_valid_o, 32'h1);
    check("rd_n3_pc", d_pc_o, 32'h100);
    advance();
    step(2);

    // Fill to DEPTH, then misaligned redirect while full and ready.
    d_ready_i = 1'b0;
    step(2);
    settle();
    check("full_req_a", imem_req_o, 32'h0);
    advance();
    settle();
    check("full_req_b", imem_req_o, 32'h0);
    check("full_head", d_pc_o, 32'h10C);
    advance();
    redirect_i = 1'b1; redirect_pc_i = 32'h103; d_ready_i = 1'b1;
    exp_q.delete();
    sb_push_seq(32'h100, 2);
    settle();
    check("mis_req", imem_req_o, 32'h0);
    check("mis_full_valid", d_valid_o, 32'h1);
    advance();
    redirect_i = 1'b0;
    settle();
    check("mis_valid", d_valid_o, 32'h0);
    check("mis_addr", imem_addr_o, 32'h100);
    advance();
    step(1);
    settle();
    check("mis_pc", d_pc_o, 32'h100);
    advance();
    step(1);

    // Fetch PC wraps past the top of the address space.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    exp_q.delete();
    sb_push_seq(32'hFFFF_FFF8, 4);
    step(1);
    redirect_i = 1'b0;
    settle();
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFF8);
    advance();
    step(1);
    settle();
    check("wrap_pc_a", d_pc_o, 32'hFFFF_FFF8);
    advance();
    settle();
    check("wrap_pc_b", d_pc_o, 32'hFFFF_FFFC);
    check("wrap_pc_plus_4_b", d_pc_plus_4_o, 32'h0);
    advance();
    settle();
    check("wrap_pc_c", d_pc_o, 32'h0);
    advance();
    step(1);

    d_ready_i = 1'b0;
    settle();
    check("end_valid", d_valid_o, 32'h1);
    check("end_head", d_pc_o, 32'h8);
    #1 rst_n = 1'b0;
    #1;
    check("end_async_valid", d_valid_o, 32'h0);
    check("end_async_pc_plus_4", d_pc_plus_4_o, 32'h0);
    check("end_async_instr", d_instr_o, 32'h0);
    check("sb_drained", exp_q.size(), 32'h0);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
